md_controller: RTL and testbench
================================

Name: md_controller

Overview:
- Multi-cycle multiply/divide controller for the MIPS 5-stage pipeline; the parametrised successor to the single-cycle ID-stage decoder.
- Decodes the R-type HI/LO instructions (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) that the main decoder does not handle.
- Runs an iterative shift-add multiplier / restoring divider, owns the HI/LO registers, and stalls ID on structural or HI/LO hazards.
- Sits beside the main controller in ID; its write-back request is OR-merged into the ID/EXE control bundle.

Parameters:
- DATA_W, 32, operand/HI/LO width. Must be even, >= 8.
- BITS_PER_CYCLE, 1, radix steps per iteration (1, 2 or 4). Must divide DATA_W.
- DIV_EN, 1, 0 removes the divider; DIV/DIVU then assert md_unrecognized.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_en  in  1  pipeline advance for the ID stage (low = ID frozen)
- inst_valid  in  1  inst is live (not bubble/flushed)
- inst  in  32  instruction in ID
- data_rs  in  DATA_W  forwarded RS value
- data_rt  in  DATA_W  forwarded RT value
- is_md  out  1  inst is one of the eight HI/LO instructions
- md_unrecognized  out  1  opcode 0, funct in 0x10-0x1B but not a legal HI/LO funct, or divide with DIV_EN=0
- rs_used  out  1  RS read by the decoded instruction
- rt_used  out  1  RT read by the decoded instruction
- stall  out  1  ID must hold; the instruction is not consumed
- wb_wen  out  1  MFHI/MFLO register write request (to rd)
- wb_data  out  DATA_W  HI or LO value for MFHI/MFLO
- busy  out  1  iterative operation in progress
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Decode: combinational. Applies only when inst[31:26]=0. Funct codes:
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
- rs_used / rt_used:
  - MTHI, MTLO: rs_used only.
  - MULT, MULTU, DIV, DIVU: rs_used and rt_used.
  - MFHI, MFLO: neither.
- Accept: fire = inst_valid & ctrl_en & is_md & ~stall.
- stall = inst_valid & is_md & busy. Every HI/LO instruction waits for the running operation; non-MD instructions never stall.
- MFHI/MFLO:
  - wb_wen = inst_valid & ~stall; wb_data = hi or lo (current register value, combinational).
  - wb_wen is 0 for every other instruction.
- MTHI/MTLO: on fire, the selected register <= data_rs at the clock edge. The other register is unchanged.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on fire of MULT/MULTU/DIV/DIVU.
    - Latch operands. Signed ops latch magnitudes plus sign flags for the result and the remainder.
    - Clear the iteration counter.
  - RUN: each cycle processes BITS_PER_CYCLE bits (shift-add multiply, restoring divide).
    - Counter width: clog2(DATA_W/BITS_PER_CYCLE)+1.
    - RUN -> FIX after DATA_W/BITS_PER_CYCLE cycles.
  - FIX: apply two's-complement sign correction, write HI/LO, FIX -> IDLE.
- busy = state != IDLE, so busy is high for DATA_W/BITS_PER_CYCLE + 1 cycles. The first dependent MFHI is accepted the cycle after FIX.
- Results:
  - MULT/MULTU: {HI,LO} = 2*DATA_W-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: no trap; still runs full latency. LO = all ones, HI = dividend (signed value for DIV).
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- An operation runs to completion regardless of ctrl_en, inst_valid or a flush. HI/LO are never written mid-operation.
- An MTHI/MTLO cannot coincide with FIX, because the stall blocks it.
- Reset (async, any state including mid-RUN):
  - state = IDLE, hi = lo = 0, counter = 0.
  - busy = 0; stall, wb_wen and all combinational outputs follow the decode of current inputs.

Test Plan:
- MULT rs=0xFFFFFFFD(-3), rt=5 (DATA_W=32, BITS_PER_CYCLE=1) -> busy high exactly 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by 0 with rs=9 -> LO=0xFFFFFFFF, HI=9 after full latency, no other flag raised.
- MFLO issued immediately after MULT -> stall=1 and wb_wen=0 for 33 cycles, then wb_wen=1 with the product LO; back-to-back MULT behaves likewise.
- MTHI rs=0x1234 then MFHI with the unit idle -> no stall, wb_data=0x1234; funct 0x14 -> md_unrecognized=1, wb_wen=0.
- rst_n pulsed low mid-RUN -> busy=0 and hi=lo=0 immediately (asynchronous); rerun with BITS_PER_CYCLE=4 -> same results, busy for 9 cycles.

Source files
------------

// File: rtl/md_controller.sv
// HI/LO multiply/divide unit for the ID stage: decodes the eight HI/LO instructions,
// runs an iterative shift-add multiplier / restoring divider and owns HI and LO.
module md_controller #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int DIV_EN         = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_en,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] data_rs,
  input  logic [DATA_W-1:0] data_rt,
  output logic              is_md,
  output logic              md_unrecognized,
  output logic              rs_used,
  output logic              rt_used,
  output logic              stall,
  output logic              wb_wen,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int STEPS = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              r_state, w_stateNext;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opA, r_opB, r_hi, r_lo;
  logic                r_isDiv, r_negRes, r_negRem, r_divZero;

  logic [5:0] w_funct;
  logic w_opZero, w_isMfhi, w_isMthi, w_isMflo, w_isMtlo;
  logic w_isMult, w_isMultu, w_isDiv, w_isDivu, w_isStart, w_isDivOp, w_signed, w_fire;
  logic w_negA, w_negB;
  logic [DATA_W-1:0] w_magA, w_magB;
  logic w_unused;

  assign w_funct   = inst[5:0];
  assign w_opZero  = (inst[31:26] == 6'd0);
  assign w_isMfhi  = w_opZero && (w_funct == 6'h10);
  assign w_isMthi  = w_opZero && (w_funct == 6'h11);
  assign w_isMflo  = w_opZero && (w_funct == 6'h12);
  assign w_isMtlo  = w_opZero && (w_funct == 6'h13);
  assign w_isMult  = w_opZero && (w_funct == 6'h18);
  assign w_isMultu = w_opZero && (w_funct == 6'h19);
  assign w_isDiv   = w_opZero && (w_funct == 6'h1A) && (DIV_EN != 0);
  assign w_isDivu  = w_opZero && (w_funct == 6'h1B) && (DIV_EN != 0);
  assign w_unused  = &{1'b0, inst[25:6]};

  assign w_isStart = w_isMult | w_isMultu | w_isDiv | w_isDivu;
  assign w_isDivOp = w_isDiv | w_isDivu;
  assign w_signed  = w_isMult | w_isDiv;

  assign is_md           = w_isMfhi | w_isMthi | w_isMflo | w_isMtlo | w_isStart;
  assign md_unrecognized = w_opZero && (w_funct >= 6'h10) && (w_funct <= 6'h1B) && !is_md;
  assign rs_used         = w_isMthi | w_isMtlo | w_isStart;
  assign rt_used         = w_isStart;

  assign busy    = (r_state != IDLE);
  assign stall   = inst_valid & is_md & busy;
  assign w_fire  = inst_valid & ctrl_en & is_md & ~stall;
  assign wb_wen  = inst_valid & ~stall & (w_isMfhi | w_isMflo);
  assign wb_data = w_isMfhi ? r_hi : r_lo;
  assign hi      = r_hi;
  assign lo      = r_lo;

  // Signed operations iterate on magnitudes; the signs are reapplied in FIX.
  assign w_negA = w_signed & data_rs[DATA_W-1];
  assign w_negB = w_signed & data_rt[DATA_W-1];
  assign w_magA = w_negA ? -data_rs : data_rs;
  assign w_magB = w_negB ? -data_rt : data_rt;

  // r_acc is {partial product, multiplier} for MULT and {remainder, quotient} for DIV.
  logic [2*DATA_W-1:0] w_acc;
  logic [DATA_W:0]     w_sum, w_remSh, w_remSub;

  always_comb begin
    w_acc    = r_acc;
    w_sum    = '0;
    w_remSh  = '0;
    w_remSub = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if ((DIV_EN != 0) && r_isDiv) begin
        w_remSh = {w_acc[2*DATA_W-1:DATA_W], w_acc[DATA_W-1]};
        if (w_remSh >= {1'b0, r_opB}) begin
          w_remSub = w_remSh - {1'b0, r_opB};
          w_acc    = {w_remSub[DATA_W-1:0], w_acc[DATA_W-2:0], 1'b1};
        end else begin
          w_acc    = {w_remSh[DATA_W-1:0], w_acc[DATA_W-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_acc[2*DATA_W-1:DATA_W]} + (w_acc[0] ? {1'b0, r_opA} : '0);
        w_acc = {w_sum, w_acc[DATA_W-1:1]};
      end
    end
  end

  // A zero divisor leaves the dividend in the remainder, so only LO needs forcing.
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_fixHi, w_fixLo;

  always_comb begin
    w_prod  = r_negRes ? -r_acc : r_acc;
    w_fixHi = w_prod[2*DATA_W-1:DATA_W];
    w_fixLo = w_prod[DATA_W-1:0];
    if (r_isDiv) begin
      w_fixHi = r_negRem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
      w_fixLo = r_divZero ? '1 : (r_negRes ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_fire && w_isStart) w_stateNext = RUN;
      RUN:     if (r_cnt == CNT_W'(STEPS - 1)) w_stateNext = FIX;
      FIX:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire && w_isStart) begin
            r_opA     <= w_magA;
            r_opB     <= w_magB;
            r_acc     <= w_isDivOp ? {{DATA_W{1'b0}}, w_magA} : {{DATA_W{1'b0}}, w_magB};
            r_isDiv   <= w_isDivOp;
            r_negRes  <= w_negA ^ w_negB;
            r_negRem  <= w_negA;
            r_divZero <= w_isDivOp && (data_rt == '0);
            r_cnt     <= '0;
          end else if (w_fire && w_isMthi) begin
            r_hi <= data_rs;
          end else if (w_fire && w_isMtlo) begin
            r_lo <= data_rs;
          end
        end
        RUN: begin
          r_acc <= w_acc;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_hi <= w_fixHi;
          r_lo <= w_fixLo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_controller.sv
// Directed bench for md_controller: radix-1 and radix-4 instances share stimulus,
// plus a divider-less instance for the decode of DIV/DIVU.
module tb_md_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_en;
  logic        inst_valid;
  logic        useDut4;
  logic        inst_valid4;
  logic [31:0] inst, data_rs, data_rt;

  logic        is_md, md_unrecognized, rs_used, rt_used, stall, wb_wen, busy;
  logic [31:0] wb_data, hi, lo;
  logic        is_md4, unrec4, rsu4, rtu4, stall4, wben4, busy4;
  logic [31:0] wbdata4, hi4, lo4;
  logic        is_md0, unrec0, rsu0, rtu0, stall0, wben0, busy0;
  logic [31:0] wbdata0, hi0, lo0;

  int testsRun = 0;
  int testsFailed = 0;
  int cnt, cnt4, n;
  logic sawWen;

  always #5 clk = ~clk;
  assign inst_valid4 = inst_valid & useDut4;

  md_controller #(.DATA_W(32), .BITS_PER_CYCLE(1), .DIV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .inst_valid(inst_valid), .inst(inst),
    .data_rs(data_rs), .data_rt(data_rt), .is_md(is_md), .md_unrecognized(md_unrecognized),
    .rs_used(rs_used), .rt_used(rt_used), .stall(stall), .wb_wen(wb_wen), .wb_data(wb_data),
    .busy(busy), .hi(hi), .lo(lo));

  md_controller #(.DATA_W(32), .BITS_PER_CYCLE(4), .DIV_EN(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .inst_valid(inst_valid4), .inst(inst),
    .data_rs(data_rs), .data_rt(data_rt), .is_md(is_md4), .md_unrecognized(unrec4),
    .rs_used(rsu4), .rt_used(rtu4), .stall(stall4), .wb_wen(wben4), .wb_data(wbdata4),
    .busy(busy4), .hi(hi4), .lo(lo4));

  md_controller #(.DATA_W(32), .BITS_PER_CYCLE(1), .DIV_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .inst_valid(1'b0), .inst(inst),
    .data_rs(data_rs), .data_rt(data_rt), .is_md(is_md0), .md_unrecognized(unrec0),
    .rs_used(rsu0), .rt_used(rtu0), .stall(stall0), .wb_wen(wben0), .wb_data(wbdata0),
    .busy(busy0), .hi(hi0), .lo(lo0));

  function automatic logic [31:0] rType(input logic [5:0] funct);
    return {6'd0, 5'd8, 5'd9, 5'd10, 5'd0, funct};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one instruction for one clock edge, then drop it and count busy cycles
  // of both iterative instances until the radix-1 unit is idle again.
  task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt);
    inst       = rType(funct);
    data_rs    = rs;
    data_rt    = rt;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    cnt  = 0;
    cnt4 = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (busy4) cnt4++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ctrl_en    = 1'b1;
    inst_valid = 1'b0;
    useDut4    = 1'b1;
    inst       = 32'd0;
    data_rs    = 32'd0;
    data_rt    = 32'd0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    inst = rType(6'h18);
    #1;
    checkOutput("dec_mult_is_md", is_md, 1);
    checkOutput("dec_mult_used", {rs_used, rt_used}, 2'b11);
    inst = rType(6'h11);
    #1;
    checkOutput("dec_mthi_used", {rs_used, rt_used}, 2'b10);
    inst = rType(6'h20);
    #1;
    checkOutput("dec_add_is_md", is_md, 0);
    inst = rType(6'h1A);
    #1;
    checkOutput("dec_div_unrec", md_unrecognized, 0);
    checkOutput("dec_div_noDiv_unrec", {is_md0, unrec0}, 2'b01);
    @(posedge clk); #1;

    applyStimulus(6'h18, 32'hFFFFFFFD, 32'd5);
    checkOutput("mult_busy", cnt, 33);
    checkOutput("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    checkOutput("mult_busy_r4", cnt4, 9);
    checkOutput("mult_res_r4", {hi4, lo4}, 64'hFFFFFFFF_FFFFFFF1);

    applyStimulus(6'h19, 32'hFFFFFFFD, 32'd5);
    checkOutput("multu_res", {hi, lo}, 64'h00000004_FFFFFFF1);
    checkOutput("multu_res_r4", {hi4, lo4}, 64'h00000004_FFFFFFF1);

    applyStimulus(6'h1B, 32'd100, 32'd7);
    checkOutput("divu_busy", cnt, 33);
    checkOutput("divu_res", {hi, lo}, {32'd2, 32'd14});
    checkOutput("divu_res_r4", {hi4, lo4}, {32'd2, 32'd14});

    applyStimulus(6'h1A, 32'hFFFFFFF9, 32'd2);
    checkOutput("div_neg_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("div_neg_res_r4", {hi4, lo4}, 64'hFFFFFFFF_FFFFFFFD);

    applyStimulus(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("div_ovf_res", {hi, lo}, 64'h00000000_80000000);
    checkOutput("div_ovf_res_r4", {hi4, lo4}, 64'h00000000_80000000);

    inst = rType(6'h1A);
    #1;
    checkOutput("div0_unrec", md_unrecognized, 0);
    applyStimulus(6'h1A, 32'd9, 32'd0);
    checkOutput("div0_busy", cnt, 33);
    checkOutput("div0_res", {hi, lo}, {32'd9, 32'hFFFFFFFF});
    applyStimulus(6'h1A, 32'hFFFFFFF7, 32'd0);
    checkOutput("div0_neg_res", {hi, lo}, 64'hFFFFFFF7_FFFFFFFF);
    checkOutput("div0_neg_res_r4", {hi4, lo4}, 64'hFFFFFFF7_FFFFFFFF);

    // MFLO held in ID right behind a MULT.
    useDut4    = 1'b0;
    inst       = rType(6'h18);
    data_rs    = 32'hFFFFFFFD;
    data_rt    = 32'd5;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst   = rType(6'h12);
    n      = 0;
    sawWen = 1'b0;
    while (stall && n < 200) begin
      if (wb_wen) sawWen = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    checkOutput("mflo_stall_cycles", n, 33);
    checkOutput("mflo_wen_during_stall", sawWen, 0);
    checkOutput("mflo_wen", wb_wen, 1);
    checkOutput("mflo_data", wb_data, 32'hFFFFFFF1);
    @(posedge clk); #1;

    // Back-to-back MULT: the second waits out the first, then runs in full.
    inst    = rType(6'h18);
    data_rs = 32'd6;
    data_rt = 32'd7;
    @(posedge clk); #1;
    data_rs = 32'hFFFFFFFE;
    data_rt = 32'd3;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("b2b_stall_cycles", n, 33);
    checkOutput("b2b_first_res", {hi, lo}, {32'd0, 32'd42});
    applyStimulus(6'h18, 32'hFFFFFFFE, 32'd3);
    checkOutput("b2b_busy", cnt, 33);
    checkOutput("b2b_second_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    applyStimulus(6'h11, 32'h00001234, 32'd0);
    inst       = rType(6'h10);
    inst_valid = 1'b1;
    #1;
    checkOutput("mfhi_stall", stall, 0);
    checkOutput("mfhi_wen", wb_wen, 1);
    checkOutput("mfhi_data", wb_data, 32'h00001234);
    checkOutput("mthi_lo_kept", lo, 32'hFFFFFFFA);
    inst = rType(6'h14);
    #1;
    checkOutput("f14_unrec", md_unrecognized, 1);
    checkOutput("f14_wen", wb_wen, 0);
    inst_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a MULT.
    useDut4    = 1'b1;
    inst       = rType(6'h18);
    data_rs    = 32'd3;
    data_rt    = 32'd3;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("pre_reset_busy", {busy, busy4}, 2'b11);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {busy, busy4}, 2'b00);
    checkOutput("async_reset_hilo", {hi, lo}, 64'd0);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", busy, 0);

    applyStimulus(6'h18, 32'hFFFFFFFD, 32'd5);
    checkOutput("rerun_busy", cnt, 33);
    checkOutput("rerun_busy_r4", cnt4, 9);
    checkOutput("rerun_res_r4", {hi4, lo4}, 64'hFFFFFFFF_FFFFFFF1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
